// File: rtl/sort_pkg.sv
// Shared types and constants for the parallel bubble sorter and its memory loader.
package sort_pkg;

    localparam int ELEM_W            = 64;
    localparam int ELEM_BYTES        = 8;
    localparam int DEFAULT_MAX_ELEMS = 64;

    typedef logic [$clog2(DEFAULT_MAX_ELEMS)-1:0] elem_idx_t;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ISSUE = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_e;

    // True when the byte range [base, base + ELEM_BYTES*count) runs past 2^64.
    function automatic logic addr_range_overflow(input logic [63:0] base,
                                                 input logic [63:0] count);
        logic [66:0] end_addr;
        end_addr = {3'b000, base} + {count, 3'b000};
        return (end_addr[66:64] != 3'b000);
    endfunction

endpackage

// File: rtl/sort_outstanding_ctr.sv
// Up/down counter of in-flight memory reads with a full flag at MAX_OUT.
module sort_outstanding_ctr #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [CNT_W-1:0] count_r;

    // In-flight count register; a simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({inc, dec})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign full  = (count_r >= CNT_W'(MAX_OUT));

endmodule

// File: rtl/sort_mem_loader.sv
// Fetches a block of 64-bit elements from memory into the sorter buffer.
// Optional response watchdog enabled by defining SORT_LOADER_TIMEOUT_EN.
import sort_pkg::*;

module sort_mem_loader #(
    parameter int MAX_ELEMS       = DEFAULT_MAX_ELEMS,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         start,
    input  logic [63:0]                  start_address,
    input  logic [63:0]                  no_of_elements,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [63:0]                  mem_req_addr,
    input  logic                         mem_rsp_valid,
    input  logic [ELEM_W-1:0]            mem_rsp_data,
    output logic                         elem_we,
    output logic [$clog2(MAX_ELEMS)-1:0] elem_idx,
    output logic [ELEM_W-1:0]            elem_data
);

    localparam int IDX_W = $clog2(MAX_ELEMS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    loader_state_e     state_r;
    loader_state_e     state_s;
    logic [63:0]       base_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  received_r;
    logic              done_r;
    logic              error_r;
    logic              elem_we_r;
    logic [IDX_W-1:0]  elem_idx_r;
    logic [ELEM_W-1:0] elem_data_r;

    logic              active_s;
    logic              req_valid_s;
    logic              xfer_s;
    logic              rsp_take_s;
    logic [CNT_W-1:0]  issued_nxt_s;
    logic [CNT_W-1:0]  received_nxt_s;
    logic              cmd_bad_s;
    logic              cmd_zero_s;
    logic              reject_s;
    logic              launch_s;
    logic              timeout_s;
    logic [OUT_W-1:0]  out_count_s;
    logic              out_full_s;

    assign active_s    = (state_r == LD_ISSUE) || (state_r == LD_DRAIN);
    assign req_valid_s = (state_r == LD_ISSUE) && (issued_r < count_r) && !out_full_s;
    assign xfer_s      = req_valid_s && mem_req_ready;
    assign rsp_take_s  = active_s && mem_rsp_valid;

    assign issued_nxt_s   = issued_r + CNT_W'(xfer_s);
    assign received_nxt_s = received_r + CNT_W'(rsp_take_s);

    assign cmd_zero_s = (no_of_elements == 64'd0);
    assign cmd_bad_s  = (no_of_elements > 64'(MAX_ELEMS))
                     || (start_address[2:0] != 3'b000)
                     || addr_range_overflow(start_address, no_of_elements);
    assign reject_s   = (state_r == LD_IDLE) && start && cmd_bad_s;
    assign launch_s   = (state_r == LD_IDLE) && start && !cmd_bad_s && !cmd_zero_s;

    // Decrement is guarded so a response with nothing in flight cannot wrap the count.
    sort_outstanding_ctr #(
        .MAX_OUT (MAX_OUTSTANDING),
        .CNT_W   (OUT_W)
    ) u_outstanding (
        .clk    (clk),
        .nreset (nreset),
        .clr    (launch_s),
        .inc    (xfer_s),
        .dec    (rsp_take_s && (out_count_s != {OUT_W{1'b0}})),
        .count  (out_count_s),
        .full   (out_full_s)
    );

`ifdef SORT_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_r;
    logic            wd_inc_s;

    assign wd_inc_s  = active_s && (out_count_s != {OUT_W{1'b0}}) && !mem_rsp_valid;
    assign timeout_s = wd_inc_s && (wd_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts silent cycles with reads in flight, cleared by any response.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (wd_inc_s) begin
            wd_r <= wd_r + WD_W'(1'b1);
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= LD_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; completion looks at this cycle's response so done trails the last write by one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LD_IDLE: begin
                if (start && !cmd_bad_s) begin
                    state_s = cmd_zero_s ? LD_DONE : LD_ISSUE;
                end else begin
                    state_s = LD_IDLE;
                end
            end
            LD_ISSUE, LD_DRAIN: begin
                if (timeout_s) begin
                    state_s = LD_IDLE;
                end else if (issued_nxt_s == count_r) begin
                    state_s = (received_nxt_s == count_r) ? LD_DONE : LD_DRAIN;
                end else begin
                    state_s = LD_ISSUE;
                end
            end
            LD_DONE: state_s = LD_IDLE;
            default: state_s = LD_IDLE;
        endcase
    end

    // Command latch and issue/receive progress counters.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            base_r     <= 64'd0;
            count_r    <= {CNT_W{1'b0}};
            issued_r   <= {CNT_W{1'b0}};
            received_r <= {CNT_W{1'b0}};
        end else if (launch_s) begin
            base_r     <= start_address;
            count_r    <= no_of_elements[CNT_W-1:0];
            issued_r   <= {CNT_W{1'b0}};
            received_r <= {CNT_W{1'b0}};
        end else begin
            issued_r   <= issued_nxt_s;
            received_r <= received_nxt_s;
        end
    end

    // Registered status pulses and buffer write port.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            elem_we_r   <= 1'b0;
            elem_idx_r  <= {IDX_W{1'b0}};
            elem_data_r <= {ELEM_W{1'b0}};
        end else begin
            done_r    <= (state_r == LD_DONE);
            error_r   <= reject_s || timeout_s;
            elem_we_r <= rsp_take_s;
            if (rsp_take_s) begin
                elem_idx_r  <= received_r[IDX_W-1:0];
                elem_data_r <= mem_rsp_data;
            end
        end
    end

    assign busy          = (state_r != LD_IDLE);
    assign done          = done_r;
    assign error         = error_r;
    assign mem_req_valid = req_valid_s;
    assign mem_req_addr  = req_valid_s ? (base_r + 64'(issued_r) * 64'(ELEM_BYTES)) : 64'd0;
    assign elem_we       = elem_we_r;
    assign elem_idx      = elem_idx_r;
    assign elem_data     = elem_data_r;

endmodule

// File: doc/sort_mem_loader.md
# sort_mem_loader

Memory read engine feeding the parallel bubble sorter's element buffer. On `start` it fetches `no_of_elements` consecutive 64-bit words from byte address `start_address` over a pipelined request/response memory port. It keeps up to `MAX_OUTSTANDING` reads in flight and writes each returned word into the sorter buffer with its index. It then pulses `done` so the sorter can leave its read phase and begin sorting.

## Interface
Parameters:
- `MAX_ELEMS`, 64: buffer depth; largest legal element count.
- `MAX_OUTSTANDING`, 4: maximum in-flight read requests (1..15).
- `TIMEOUT_CYCLES`, 1024: response watchdog limit (used only with `SORT_LOADER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock
- `nreset`  in  1  asynchronous, active-low reset
- `start`  in  1  start pulse, sampled only in IDLE
- `start_address`  in  64  byte address of element 0
- `no_of_elements`  in  64  element count
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when the load completes
- `error`  out  1  one-cycle pulse when a command is rejected or aborted
- `mem_req_valid`  out  1  read request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_addr`  out  64  request byte address
- `mem_rsp_valid`  in  1  read data valid; responses arrive in order and are always accepted
- `mem_rsp_data`  in  64  read data
- `elem_we`  out  1  buffer write strobe
- `elem_idx`  out  $clog2(MAX_ELEMS)  buffer index
- `elem_data`  out  64  element value

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- **IDLE:** on `start`, validate the command.
  - A count of 0 goes to DONE.
  - A count greater than `MAX_ELEMS` is rejected: pulse `error` and stay in IDLE.
  - `start_address[2:0] != 0` is rejected the same way.
  - `start_address + 8*count` overflowing 64 bits is rejected the same way.
  - Otherwise latch the base address and count, clear the counters, and go to ISSUE.
- **ISSUE:** assert `mem_req_valid` while issued < count and outstanding < `MAX_OUTSTANDING`.
  - `mem_req_addr` = base + 8*issued.
  - A request is transferred when `mem_req_valid && mem_req_ready`; issued then increments.
  - When issued == count, go to DRAIN.
- **Response handling (ISSUE or DRAIN):** each `mem_rsp_valid` writes `mem_rsp_data` to index received, then received increments.
- **DRAIN:** go to DONE when received == count.
- **DONE:** pulse `done` for one cycle, then return to IDLE.
- **Outstanding count:** +1 per transfer, −1 per response. A transfer and a response in the same cycle leave it unchanged.
- **Stray responses:** any `mem_rsp_valid` in IDLE or DONE is ignored and produces no `elem_we`.
- **`start` while busy:** ignored.
- **Arithmetic:** counters are $clog2(MAX_ELEMS)+1 bits wide; address arithmetic is 64-bit unsigned.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters 0.
- **Reset mid-operation:** aborts immediately; no `done` or `error`. Responses arriving after reset are ignored.
- **First request:** `mem_req_valid` first asserts the cycle after `start` is accepted.
- **Request hold:** `mem_req_valid` and `mem_req_addr` are held stable until `mem_req_ready`.
- **Element writes:** `elem_we`, `elem_idx` and `elem_data` are registered, so each appears one cycle after its `mem_rsp_valid`.
- **`done`:** asserted the cycle after the final `elem_we`. For a zero count it is asserted 2 cycles after `start`.
- **`error` on rejection:** asserted the cycle after `start`.
- **Throughput:** one request per cycle when the memory returns one response per cycle.

## Configuration
- **Macro:** `SORT_LOADER_TIMEOUT_EN`.
- **When defined:**
  - A watchdog counts cycles with outstanding > 0 and no `mem_rsp_valid`; it resets on any response.
  - When the count reaches `TIMEOUT_CYCLES`, the loader pulses `error`, suppresses `done`, returns to IDLE, and ignores later responses.
- **When undefined:** no watchdog logic; the loader waits indefinitely.

## Structure
- **Package `sort_pkg`:**
  - the loader state enum;
  - `ELEM_W = 64`;
  - `ELEM_BYTES = 8`;
  - the default `MAX_ELEMS`;
  - an `elem_idx_t` typedef shared with the sorter.
- **Sub-module `sort_outstanding_ctr`:** up/down in-flight counter with a full flag, instantiated once.

## Test plan
- count=8, addr=0x1000, `mem_req_ready`=1, 2-cycle response latency → 8 requests to 0x1000..0x1038; `elem_idx` 0..7 carry the matching data; `done` follows the last `elem_we` by 1 cycle.
- count=10, `mem_req_ready` held low until the memory has accepted 4 requests and returned none → `mem_req_valid` deasserts at outstanding=4 and resumes after the next response.
- count=0 → `done` 2 cycles after `start`; no requests issued. count=65 → `error`, no requests. addr=0x1004 → `error`, no requests.
- Response arriving in the same cycle as a request transfer while 3 are in flight → outstanding stays at 3 and all data arrives in order.
- `nreset` asserted after 3 of 8 responses → all outputs 0 immediately. Late responses produce no `elem_we`. A following `start` works normally.
- With `SORT_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, the memory stops responding → `error` after 16 idle cycles, no `done`, `busy` drops.
